// File: rtl/rs_queue.sv
// Reservation station: holds issued ops until both operands are ready, dispatches oldest-first on two ports.
// Latency: an entry written or woken at edge N is dispatchable from cycle N+1; dispatch outputs are combinational from entry state.
// Backpressure: in_ready drops when all DEPTH entries are occupied (registered count); dK_ready=0 holds the selected entry in place.
//
// Ports:
//   clk, rst (async, active-low), flush (kill all entries), count (occupied entries)
//   in_*      : allocation of one op per cycle, operands either ready (value) or waiting (tag)
//   cdb_*     : NCDB result-broadcast ports, port i at slice i of the packed vectors
//   d0_*/d1_* : oldest and second-oldest fully-ready entries, valid/ready handshake each
module rs_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int TW    = 5,
  parameter int OPW   = 6,
  parameter int NCDB  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPW-1:0]            in_op,
  input  logic [TW-1:0]             in_dest,
  input  logic                      in_a_rdy,
  input  logic [DW-1:0]             in_a,
  input  logic [TW-1:0]             in_a_tag,
  input  logic                      in_b_rdy,
  input  logic [DW-1:0]             in_b,
  input  logic [TW-1:0]             in_b_tag,
  input  logic [NCDB-1:0]           cdb_valid,
  input  logic [NCDB*TW-1:0]        cdb_tag,
  input  logic [NCDB*DW-1:0]        cdb_data,
  output logic                      d0_valid,
  input  logic                      d0_ready,
  output logic [OPW-1:0]            d0_op,
  output logic [TW-1:0]             d0_dest,
  output logic [DW-1:0]             d0_a,
  output logic [DW-1:0]             d0_b,
  output logic                      d1_valid,
  input  logic                      d1_ready,
  output logic [OPW-1:0]            d1_op,
  output logic [TW-1:0]             d1_dest,
  output logic [DW-1:0]             d1_a,
  output logic [DW-1:0]             d1_b
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // rank = number of older valid entries; 0 is the oldest. Ranks of valid
  // entries are always a dense, unique set 0..count-1.
  typedef struct packed {
    logic           vld;
    logic [OPW-1:0] op;
    logic [TW-1:0]  dest;
    logic           a_rdy;
    logic [DW-1:0]  a_val;
    logic [TW-1:0]  a_tag;
    logic           b_rdy;
    logic [DW-1:0]  b_val;
    logic [TW-1:0]  b_tag;
    logic [IW-1:0]  rank;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] rdy_all;
  logic             sel0_vld, sel1_vld;
  logic [IW-1:0]    sel0_idx, sel1_idx;
  logic             d0_fire, d1_fire, alloc, alloc_found;
  logic [IW-1:0]    alloc_idx;
  logic [CW-1:0]    ndisp, dec, new_rank;
  logic [DW:0]      lk;
  entry_t           new_ent;

  // Returns {hit, data}; scanning from the top down lets the lowest port win.
  function automatic logic [DW:0] cdb_lookup(
    input logic [TW-1:0]      tag,
    input logic [NCDB-1:0]    vld,
    input logic [NCDB*TW-1:0] tags,
    input logic [NCDB*DW-1:0] data
  );
    logic [DW:0] r;
    r = '0;
    for (int p = NCDB - 1; p >= 0; p--) begin
      if (vld[p] && tags[p*TW +: TW] == tag) r = {1'b1, data[p*DW +: DW]};
    end
    return r;
  endfunction

  // Oldest and second-oldest fully-ready entries.
  always_comb begin
    sel0_vld = 1'b0;
    sel0_idx = '0;
    sel1_vld = 1'b0;
    sel1_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_all[i] = ent_q[i].vld & ent_q[i].a_rdy & ent_q[i].b_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_all[i] && (!sel0_vld || ent_q[i].rank < ent_q[sel0_idx].rank)) begin
        sel0_vld = 1'b1;
        sel0_idx = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_all[i] && IW'(i) != sel0_idx &&
          (!sel1_vld || ent_q[i].rank < ent_q[sel1_idx].rank)) begin
        sel1_vld = 1'b1;
        sel1_idx = IW'(i);
      end
    end
  end

  always_comb begin
    ent_d       = ent_q;
    d0_fire     = sel0_vld & d0_ready;
    d1_fire     = sel1_vld & d1_ready;
    ndisp       = {{(CW-1){1'b0}}, d0_fire} + {{(CW-1){1'b0}}, d1_fire};
    alloc       = in_valid & in_ready;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    lk          = '0;
    dec         = '0;
    new_rank    = count_q - ndisp;
    new_ent     = '0;

    // Only slots free in registered state are eligible for allocation.
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].vld && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      // Close the gaps left by dispatched older entries to keep ranks dense.
      dec = '0;
      if (d0_fire && ent_q[sel0_idx].rank < ent_q[i].rank) dec = dec + 1'b1;
      if (d1_fire && ent_q[sel1_idx].rank < ent_q[i].rank) dec = dec + 1'b1;
      ent_d[i].rank = ent_q[i].rank - dec[IW-1:0];

      if (ent_q[i].vld && !ent_q[i].a_rdy) begin
        lk = cdb_lookup(ent_q[i].a_tag, cdb_valid, cdb_tag, cdb_data);
        if (lk[DW]) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = lk[DW-1:0];
        end
      end
      if (ent_q[i].vld && !ent_q[i].b_rdy) begin
        lk = cdb_lookup(ent_q[i].b_tag, cdb_valid, cdb_tag, cdb_data);
        if (lk[DW]) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = lk[DW-1:0];
        end
      end

      if ((d0_fire && sel0_idx == IW'(i)) || (d1_fire && sel1_idx == IW'(i))) begin
        ent_d[i].vld = 1'b0;
      end
    end

    if (alloc) begin
      new_ent.vld   = 1'b1;
      new_ent.op    = in_op;
      new_ent.dest  = in_dest;
      new_ent.a_tag = in_a_tag;
      new_ent.b_tag = in_b_tag;
      new_ent.rank  = new_rank[IW-1:0];
      // A broadcast in the allocation cycle would otherwise be lost.
      if (in_a_rdy) begin
        new_ent.a_rdy = 1'b1;
        new_ent.a_val = in_a;
      end else begin
        lk            = cdb_lookup(in_a_tag, cdb_valid, cdb_tag, cdb_data);
        new_ent.a_rdy = lk[DW];
        new_ent.a_val = lk[DW-1:0];
      end
      if (in_b_rdy) begin
        new_ent.b_rdy = 1'b1;
        new_ent.b_val = in_b;
      end else begin
        lk            = cdb_lookup(in_b_tag, cdb_valid, cdb_tag, cdb_data);
        new_ent.b_rdy = lk[DW];
        new_ent.b_val = lk[DW-1:0];
      end
      ent_d[alloc_idx] = new_ent;
    end

    count_d = count_q + {{(CW-1){1'b0}}, alloc} - ndisp;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].vld = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign in_ready = (count_q < CW'(DEPTH));

  assign d0_valid = sel0_vld;
  assign d0_op    = sel0_vld ? ent_q[sel0_idx].op    : '0;
  assign d0_dest  = sel0_vld ? ent_q[sel0_idx].dest  : '0;
  assign d0_a     = sel0_vld ? ent_q[sel0_idx].a_val : '0;
  assign d0_b     = sel0_vld ? ent_q[sel0_idx].b_val : '0;

  assign d1_valid = sel1_vld;
  assign d1_op    = sel1_vld ? ent_q[sel1_idx].op    : '0;
  assign d1_dest  = sel1_vld ? ent_q[sel1_idx].dest  : '0;
  assign d1_a     = sel1_vld ? ent_q[sel1_idx].a_val : '0;
  assign d1_b     = sel1_vld ? ent_q[sel1_idx].b_val : '0;

endmodule

// File: tb/tb_rs_queue.sv
// Directed bench for rs_queue with DEPTH=4, two CDB ports.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// All expected values are hand-computed constants in the stimulus below.
module tb_rs_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  count;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_dest;
  logic        in_a_rdy, in_b_rdy;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_a_tag, in_b_tag;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        d0_valid, d0_ready, d1_valid, d1_ready;
  logic [5:0]  d0_op, d1_op;
  logic [4:0]  d0_dest, d1_dest;
  logic [31:0] d0_a, d0_b, d1_a, d1_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_queue #(.DEPTH(4), .DW(32), .TW(5), .OPW(6), .NCDB(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dest(in_dest),
    .in_a_rdy(in_a_rdy), .in_a(in_a), .in_a_tag(in_a_tag),
    .in_b_rdy(in_b_rdy), .in_b(in_b), .in_b_tag(in_b_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_op(d0_op), .d0_dest(d0_dest),
    .d0_a(d0_a), .d0_b(d0_b),
    .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_op(d1_op), .d1_dest(d1_dest),
    .d1_a(d1_a), .d1_b(d1_b)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] dest,
                       input logic ar, input logic [31:0] a, input logic [4:0] at,
                       input logic br, input logic [31:0] b, input logic [4:0] bt);
    in_valid = 1'b1;
    in_op    = op;
    in_dest  = dest;
    in_a_rdy = ar;
    in_a     = a;
    in_a_tag = at;
    in_b_rdy = br;
    in_b     = b;
    in_b_tag = bt;
  endtask

  task automatic bcast(input int p, input logic [4:0] tag, input logic [31:0] data);
    cdb_valid[p]         = 1'b1;
    cdb_tag[p*5 +: 5]    = tag;
    cdb_data[p*32 +: 32] = data;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_dest = '0; in_a_rdy = 1'b0; in_a = '0; in_a_tag = '0;
    in_b_rdy = 1'b0; in_b = '0; in_b_tag = '0;
    d0_ready = 1'b0; d1_ready = 1'b0;
    cdb_clear();

    // Reset state
    tick(); tick();
    chk_eq("rst_count", count, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_d0_valid", d0_valid, 0);
    chk_eq("rst_d1_valid", d1_valid, 0);
    chk_eq("rst_d0_a", d0_a, 0);
    rst = 1'b1;
    tick();

    // Basic issue -> dispatch next cycle
    d0_ready = 1'b1;
    issue(6'd3, 5'd9, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    tick();
    in_valid = 1'b0;
    chk_eq("basic_d0_valid", d0_valid, 1);
    chk_eq("basic_d0_op", d0_op, 3);
    chk_eq("basic_d0_a", d0_a, 5);
    chk_eq("basic_d0_b", d0_b, 7);
    chk_eq("basic_d0_dest", d0_dest, 9);
    chk_eq("basic_count1", count, 1);
    tick();
    chk_eq("basic_count0", count, 0);
    chk_eq("basic_d0_idle", d0_valid, 0);

    // Wakeup via CDB port 1
    issue(6'd1, 5'd2, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd4);
    tick();
    in_valid = 1'b0;
    chk_eq("wake_wait_valid", d0_valid, 0);
    chk_eq("wake_wait_count", count, 1);
    tick(); tick();
    chk_eq("wake_still_wait", d0_valid, 0);
    bcast(1, 5'd4, 32'hAB);
    tick();
    cdb_clear();
    chk_eq("wake_d0_valid", d0_valid, 1);
    chk_eq("wake_d0_b", d0_b, 32'hAB);
    tick();
    chk_eq("wake_count0", count, 0);

    // Bypass: broadcast in the allocation cycle
    issue(6'd2, 5'd3, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd4);
    bcast(1, 5'd4, 32'hCD);
    tick();
    in_valid = 1'b0;
    cdb_clear();
    chk_eq("bypass_d0_valid", d0_valid, 1);
    chk_eq("bypass_d0_b", d0_b, 32'hCD);
    tick();
    chk_eq("bypass_count0", count, 0);

    // Two ports hit the same tag: lowest port wins
    d0_ready = 1'b0;
    issue(6'd4, 5'd5, 1'b0, 32'd0, 5'd6, 1'b1, 32'd2, 5'd0);
    tick();
    in_valid = 1'b0;
    bcast(0, 5'd6, 32'h11);
    bcast(1, 5'd6, 32'h22);
    tick();
    cdb_clear();
    chk_eq("prio_d0_valid", d0_valid, 1);
    chk_eq("prio_d0_a", d0_a, 32'h11);
    d0_ready = 1'b1;
    tick();
    chk_eq("prio_count0", count, 0);

    // Fill to full, back-pressure, partial dispatch, reuse of freed slot
    d0_ready = 1'b0; d1_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(6'd1, 5'(k), 1'b1, 32'(10 + k), 5'd0, 1'b1, 32'd0, 5'd0);
      tick();
    end
    chk_eq("full_count", count, 4);
    chk_eq("full_in_ready", in_ready, 0);
    issue(6'd1, 5'd7, 1'b1, 32'd17, 5'd0, 1'b1, 32'd0, 5'd0);
    tick();
    chk_eq("full_ignored", count, 4);
    chk_eq("full_d0_dest", d0_dest, 0);
    chk_eq("full_d1_dest", d1_dest, 1);
    d1_ready = 1'b1;
    chk_eq("full_in_ready_same", in_ready, 0);
    tick();
    d1_ready = 1'b0;
    chk_eq("d1only_count", count, 3);
    chk_eq("d1only_in_ready", in_ready, 1);
    chk_eq("d1only_d0_dest", d0_dest, 0);
    chk_eq("d1only_d1_dest", d1_dest, 2);
    tick();
    in_valid = 1'b0;
    chk_eq("refill_count", count, 4);
    d0_ready = 1'b1; d1_ready = 1'b1;
    tick();
    chk_eq("age_count2", count, 2);
    chk_eq("age_d0_dest", d0_dest, 3);
    chk_eq("age_d1_dest", d1_dest, 7);
    chk_eq("age_d1_a", d1_a, 17);
    tick();
    chk_eq("age_count0", count, 0);

    // Four entries woken together drain two per cycle, oldest first
    for (int k = 0; k < 4; k++) begin
      issue(6'd2, 5'(k), 1'b0, 32'd0, 5'd8, 1'b1, 32'(k), 5'd0);
      tick();
    end
    in_valid = 1'b0;
    chk_eq("drain_pre_count", count, 4);
    chk_eq("drain_pre_valid", d0_valid, 0);
    bcast(0, 5'd8, 32'h55);
    tick();
    cdb_clear();
    chk_eq("drain_c1_count", count, 4);
    chk_eq("drain_c1_d0_dest", d0_dest, 0);
    chk_eq("drain_c1_d1_dest", d1_dest, 1);
    chk_eq("drain_c1_d0_a", d0_a, 32'h55);
    tick();
    chk_eq("drain_c2_count", count, 2);
    chk_eq("drain_c2_d0_dest", d0_dest, 2);
    chk_eq("drain_c2_d1_dest", d1_dest, 3);
    chk_eq("drain_c2_d1_b", d1_b, 3);
    tick();
    chk_eq("drain_c3_count", count, 0);
    chk_eq("drain_c3_valid", d0_valid, 0);

    // Flush beats allocation and dispatch
    d0_ready = 1'b0; d1_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(6'd5, 5'(k), 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
      tick();
    end
    chk_eq("flush_pre_count", count, 3);
    chk_eq("flush_pre_valid", d0_valid, 1);
    issue(6'd5, 5'd9, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
    flush = 1'b1; d0_ready = 1'b1; d1_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_eq("flush_count", count, 0);
    chk_eq("flush_d0_valid", d0_valid, 0);
    chk_eq("flush_d1_valid", d1_valid, 0);
    chk_eq("flush_in_ready", in_ready, 1);

    // Asynchronous reset mid-stream
    d0_ready = 1'b0; d1_ready = 1'b0;
    issue(6'd6, 5'd4, 1'b1, 32'h33, 5'd0, 1'b1, 32'h44, 5'd0);
    tick();
    issue(6'd6, 5'd5, 1'b1, 32'h35, 5'd0, 1'b1, 32'h46, 5'd0);
    tick();
    in_valid = 1'b0;
    chk_eq("arst_pre_count", count, 2);
    chk_eq("arst_pre_d0_a", d0_a, 32'h33);
    #2;
    rst = 1'b0;
    #1;
    chk_eq("arst_count", count, 0);
    chk_eq("arst_d0_valid", d0_valid, 0);
    chk_eq("arst_d1_valid", d1_valid, 0);
    chk_eq("arst_d0_a", d0_a, 0);
    chk_eq("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    issue(6'd1, 5'd6, 1'b1, 32'h66, 5'd0, 1'b1, 32'h77, 5'd0);
    tick();
    in_valid = 1'b0;
    chk_eq("post_count", count, 1);
    chk_eq("post_d0_dest", d0_dest, 6);
    chk_eq("post_d0_b", d0_b, 32'h77);
    chk_eq("post_d1_valid", d1_valid, 0);
    d0_ready = 1'b1;
    tick();
    chk_eq("post_count0", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
